// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute stage of the pipelined RISC-V core. Takes the 3-bit ALU control code
// and the two operands held in ID/EX, computes the ALU result and parks it in a
// single-entry EX/MEM buffer with a valid/ready handshake. The buffer supports
// full throughput (a consume and an accept in the same cycle replace the entry
// without a bubble), a flush that kills both the buffered and the incoming
// instruction, a sticky illegal-opcode flag and a saturating counter of
// results consumed by the MEM stage.
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       ID/EX holds a valid instruction
//   in_ready       stage can accept this cycle (combinational, ignores flush)
//   alu_control    000 add, 001 sub, 010 and, 011 or, 101 slt, 110 xor;
//                  100 and 111 are illegal
//   op_a, op_b     operands (XLEN bits)
//   rd_in          destination register
//   reg_write_in   instruction writes rd
//   flush          kill buffered and incoming instruction
//   out_valid      EX/MEM buffer holds a valid result
//   out_ready      MEM stage consumes this cycle
//   result         registered ALU result
//   zero           registered (result == 0)
//   rd_out         registered destination
//   reg_write_out  registered write enable, 0 whenever out_valid is 0
//   illegal_op     sticky: an illegal alu_control code was accepted
//   ops_retired    saturating count of consumed results (CNT_W bits)
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic [4:0]       rd_out,
    output logic             reg_write_out,
    output logic             illegal_op,
    output logic [CNT_W-1:0] ops_retired
);

    // ALU control encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // True for every code the ALU implements; 100 and 111 are illegal.
    function automatic logic alu_is_legal(input logic [2:0] ctrl);
        logic legal;
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_AND,
            ALU_OR,  ALU_SLT, ALU_XOR: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

    // ALU datapath. Illegal codes produce zero so the buffered value is
    // well defined.
    function automatic logic [XLEN-1:0] alu_compute(
        input logic [2:0]      ctrl,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
        case (ctrl)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_XOR: res = a ^ b;
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    // Buffer state
    logic             out_valid_q,     out_valid_d;
    logic [XLEN-1:0]  result_q,        result_d;
    logic             zero_q,          zero_d;
    logic [4:0]       rd_q,            rd_d;
    logic             reg_write_q,     reg_write_d;
    logic             illegal_q,       illegal_d;
    logic [CNT_W-1:0] ops_retired_q,   ops_retired_d;

    // Handshake terms
    logic             accept_s;
    logic             consume_s;
    logic             legal_s;
    logic [XLEN-1:0]  alu_res_s;

    // The slot can take a new op when it is empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;

    // Handshake qualification and ALU evaluation for the incoming op.
    always_comb begin
        accept_s  = in_valid && in_ready && !flush;
        consume_s = out_valid_q && out_ready;
        legal_s   = alu_is_legal(alu_control);
        alu_res_s = alu_compute(alu_control, op_a, op_b);
    end

    // Next-state for the EX/MEM buffer. Flush has priority over accept; a
    // drained or flushed slot always has its write enable cleared so that
    // reg_write_out can never be seen high with out_valid low.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            rd_d        = rd_in;
            if (legal_s) begin
                result_d    = alu_res_s;
                zero_d      = (alu_res_s == {XLEN{1'b0}});
                reg_write_d = reg_write_in;
            end else begin
                result_d    = {XLEN{1'b0}};
                zero_d      = 1'b1;
                reg_write_d = 1'b0;
            end
        end else if (consume_s) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Next-state for the sticky illegal flag and the retired-op counter.
    // A consume still counts in a flush cycle.
    always_comb begin
        illegal_d     = illegal_q;
        ops_retired_d = ops_retired_q;
        if (accept_s && !legal_s) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
        if (consume_s && (ops_retired_q != CNT_MAX)) begin
            ops_retired_d = ops_retired_q + CNT_ONE;
        end else begin
            ops_retired_d = ops_retired_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            result_q      <= {XLEN{1'b0}};
            zero_q        <= 1'b0;
            rd_q          <= 5'd0;
            reg_write_q   <= 1'b0;
            illegal_q     <= 1'b0;
            ops_retired_q <= {CNT_W{1'b0}};
        end else begin
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            zero_q        <= zero_d;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
            illegal_q     <= illegal_d;
            ops_retired_q <= ops_retired_d;
        end
    end

    // All outputs other than in_ready come straight from flops.
    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign rd_out        = rd_q;
    assign reg_write_out = reg_write_q;
    assign illegal_op    = illegal_q;
    assign ops_retired   = ops_retired_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, hand-written
// handshake/flush/illegal/reset/saturation sequences, and a random phase, all
// checked against a transaction-level model of the single-entry buffer.
module tb_alu_exec_stage;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       alu_control = 3'b000;
    logic [XLEN-1:0]  op_a = '0;
    logic [XLEN-1:0]  op_b = '0;
    logic [4:0]       rd_in = 5'd0;
    logic             reg_write_in = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  result;
    logic             zero;
    logic [4:0]       rd_out;
    logic             reg_write_out;
    logic             illegal_op;
    logic [CNT_W-1:0] ops_retired;

    always #5 clk = ~clk;

    alu_exec_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .illegal_op(illegal_op),
        .ops_retired(ops_retired)
    );

    int total = 0;
    int bad   = 0;

    // Model: contents of the output slot plus sticky flag and counter.
    logic            m_valid;
    logic [XLEN-1:0] m_result;
    logic            m_zero;
    logic [4:0]      m_rd;
    logic            m_rw;
    logic            m_ill;
    int              m_cnt;

    typedef struct {
        logic [2:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic [XLEN-1:0] exp_res;
        logic            exp_zero;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the instruction semantics; legal=0 for 100/111.
    function automatic logic [XLEN-1:0] ref_alu(input logic [2:0] c, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b, output logic legal);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        legal = 1'b1;
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd6:    return a ^ b;
            default: begin legal = 1'b0; return 32'd0; end
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_result = '0; m_zero = 1'b0; m_rd = 5'd0;
        m_rw = 1'b0; m_ill = 1'b0; m_cnt = 0;
    endtask

    task automatic check_model();
        check("out_valid", out_valid, m_valid);
        check("reg_write_out", reg_write_out, m_rw);
        check("illegal_op", illegal_op, m_ill);
        check("ops_retired", ops_retired, m_cnt);
        if (m_valid) begin
            check("result", result, m_result);
            check("zero", zero, m_zero);
            check("rd_out", rd_out, m_rd);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_zero"}, zero, 1'b0);
        check({tag, "_rd_out"}, rd_out, 5'd0);
        check({tag, "_reg_write_out"}, reg_write_out, 1'b0);
        check({tag, "_illegal_op"}, illegal_op, 1'b0);
        check({tag, "_ops_retired"}, ops_retired, 0);
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks in_ready,
    // advances the model, then checks outputs at the next posedge+1.
    task automatic cycle(input logic iv, input logic [2:0] c, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [4:0] rd, input logic rw,
                         input logic fl, input logic ordy);
        logic m_ready, acc, cons, legal;
        logic [XLEN-1:0] r;
        in_valid = iv; alu_control = c; op_a = a; op_b = b; rd_in = rd;
        reg_write_in = rw; flush = fl; out_ready = ordy;
        #1;
        m_ready = !m_valid || ordy;
        check("in_ready", in_ready, m_ready);
        acc  = iv && m_ready && !fl;
        cons = m_valid && ordy;
        if (cons && m_cnt < CNT_MAX) m_cnt++;
        if (fl) begin
            m_valid = 1'b0; m_rw = 1'b0;
        end else if (acc) begin
            r = ref_alu(c, a, b, legal);
            m_valid = 1'b1;
            m_rd = rd;
            if (legal) begin
                m_result = r; m_zero = (r == 0); m_rw = rw;
            end else begin
                m_result = '0; m_zero = 1'b1; m_rw = 1'b0; m_ill = 1'b1;
            end
        end else if (cons) begin
            m_valid = 1'b0; m_rw = 1'b0;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 3'd0, '0, '0, 5'd0, 1'b0, 1'b0, ordy);
    endtask

    // Synchronous-looking reset pulse; leaves the bench at posedge+1.
    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'd7,        32'd5,        5'd1, 32'd12,       1'b0};
        vecs[1] = '{3'd1, 32'd9,        32'd9,        5'd2, 32'd0,        1'b1};
        vecs[2] = '{3'd1, 32'd0,        32'd1,        5'd3, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{3'd5, 32'hFFFFFFFF, 32'd1,        5'd4, 32'd1,        1'b0};
        vecs[4] = '{3'd5, 32'd1,        32'hFFFFFFFF, 5'd5, 32'd0,        1'b1};
        vecs[5] = '{3'd6, 32'h0000F0F0, 32'h0000FF00, 5'd6, 32'h00000FF0, 1'b0};
        vecs[6] = '{3'd2, 32'h0000F0F0, 32'h0000FF00, 5'd7, 32'h0000F000, 1'b0};
        vecs[7] = '{3'd3, 32'h0000F0F0, 32'h0000FF00, 5'd8, 32'h0000FFF0, 1'b0};
        vecs[8] = '{3'd0, 32'hFFFFFFFF, 32'd1,        5'd9, 32'd0,        1'b1};

        // Reset state and idle
        do_reset();
        check_cleared("reset");
        check("reset_in_ready", in_ready, 1'b1);
        idle(1'b0);

        // Directed vector table, one op at a time
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, 1'b0, 1'b1);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_zero);
            check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            idle(1'b1);
        end

        // Back-to-back stream of 4 with out_ready high
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 3'd0, 32'd100, 32'(i), 5'(i + 10), 1'b1, 1'b0, 1'b1);
            check($sformatf("stream%0d_result", i), result, 32'(100 + i));
        end
        idle(1'b1);
        check("stream_retired", ops_retired, 4);
        check("stream_drained", out_valid, 1'b0);

        // Stall: out_ready low for 2 cycles while a new op waits
        cycle(1'b1, 3'd0, 32'd40, 32'd2, 5'd20, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 3'd1, 32'd50, 32'd8, 5'd21, 1'b1, 1'b0, 1'b0);
        check("stall1_result", result, 32'd42);
        cycle(1'b1, 3'd1, 32'd50, 32'd8, 5'd21, 1'b1, 1'b0, 1'b0);
        check("stall2_result", result, 32'd42);
        check("stall_in_ready", in_ready, 1'b0);
        cycle(1'b1, 3'd1, 32'd50, 32'd8, 5'd21, 1'b1, 1'b0, 1'b1);
        check("stall_release_result", result, 32'd42 - 32'd0 + 32'd0 == 32'd42 ? 32'd42 : 32'd0);
        idle(1'b1);
        check("stall_retired", ops_retired, 6);

        // Flush with a buffered, unconsumed result and an incoming op
        cycle(1'b1, 3'd3, 32'h0F, 32'hF0, 5'd22, 1'b1, 1'b0, 1'b0);
        check("preflush_valid", out_valid, 1'b1);
        cycle(1'b1, 3'd0, 32'd1, 32'd1, 5'd23, 1'b1, 1'b1, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_rw", reg_write_out, 1'b0);
        idle(1'b1);
        check("flush_no_op", out_valid, 1'b0);
        check("flush_retired", ops_retired, 6);

        // Illegal code, sticky across later legal ops
        cycle(1'b1, 3'b100, 32'd3, 32'd4, 5'd24, 1'b1, 1'b0, 1'b1);
        check("illegal_result", result, 32'd0);
        check("illegal_zero", zero, 1'b1);
        check("illegal_rw", reg_write_out, 1'b0);
        check("illegal_flag", illegal_op, 1'b1);
        cycle(1'b1, 3'd0, 32'd3, 32'd4, 5'd25, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        check("illegal_sticky", illegal_op, 1'b1);

        // Asynchronous reset mid-cycle with a result buffered
        cycle(1'b1, 3'd0, 32'd5, 32'd5, 5'd26, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async");
        model_reset();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model();

        // Counter saturation: reach max-1, then two more consumes
        for (int i = 0; i < CNT_MAX - 1; i++) cycle(1'b1, 3'd0, 32'(i), 32'd1, 5'd1, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        check("sat_pre", ops_retired, CNT_MAX - 1);
        cycle(1'b1, 3'd0, 32'd1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 3'd0, 32'd2, 32'd1, 5'd1, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        check("sat_hold", ops_retired, CNT_MAX);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [XLEN-1:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : XLEN'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage of the pipelined RISC-V core, directly downstream of the ALU control decoder.
- Consumes the 3-bit ALU control code plus the two operands and destination info held in ID/EX.
- Performs the ALU operation and registers the result into a single-entry EX/MEM output buffer with valid/ready handshake, flush and a retired-op counter.
- Branch logic and memory stage read the registered result and zero flag.

Parameters:
- XLEN, 32, operand/result width in bits.
- CNT_W, 16, width of the saturating retired-operation counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ID/EX holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- alu_control  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 xor; 100/111 illegal.
- op_a  input  XLEN  first operand (rs1 value).
- op_b  input  XLEN  second operand (rs2 value or immediate).
- rd_in  input  5  destination register.
- reg_write_in  input  1  instruction writes rd.
- flush  input  1  kill buffered and incoming instruction (branch taken).
- out_valid  output  1  EX/MEM buffer holds a valid result.
- out_ready  input  1  MEM stage consumes this cycle.
- result  output  XLEN  registered ALU result.
- zero  output  1  registered (result == 0).
- rd_out  output  5  registered destination.
- reg_write_out  output  1  registered write enable, forced 0 when out_valid is 0.
- illegal_op  output  1  sticky flag: an illegal alu_control code was accepted.
- ops_retired  output  CNT_W  count of results consumed by MEM stage.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, result=0, zero=0, rd_out=0, reg_write_out=0, illegal_op=0, ops_retired=0. Reset mid-transfer discards the buffered result.
- in_ready = !out_valid || out_ready (combinational). It ignores flush.
- accept = in_valid && in_ready && !flush. On accept, the next edge loads result, zero, rd_out and reg_write_out, and sets out_valid=1. Latency is 1 cycle.
- Consume = out_valid && out_ready. With consume and no accept, out_valid goes to 0 next edge. Simultaneous consume and accept replaces the buffer with no bubble, giving full throughput.
- out_valid && !out_ready && in_valid: hold all registers, no accept. The upstream stage stalls.
- flush: out_valid goes to 0 next edge and the incoming instruction is dropped. ops_retired still increments if consume occurs that same cycle. result, rd_out and zero may hold stale values, but reg_write_out is forced 0.
- Arithmetic:
  - add/sub: modulo 2^XLEN, carry discarded.
  - slt: signed two's-complement compare, result {0…0, op_a<op_b}.
  - and/or/xor: bitwise.
- Illegal code on accept: result=0, zero=1, reg_write_out=0, illegal_op set. illegal_op clears only on reset.
- ops_retired increments on each consume and saturates at all-ones (no wrap).

Test Plan:
- Reset then idle -> all outputs 0, in_ready=1.
- add 7+5, out_ready=1 -> next cycle out_valid=1, result=12, zero=0. sub 9-9 -> result=0, zero=1. sub 0-1 -> 0xFFFFFFFF.
- slt with op_a=0xFFFFFFFF, op_b=1 -> result 1. With op_a=1, op_b=0xFFFFFFFF -> result 0. xor 0xF0F0 with 0xFF00 -> 0x0FF0.
- Back-to-back stream of 4 ops with out_ready held 1 -> 4 results on consecutive cycles, ops_retired=4. Drop out_ready for 2 cycles mid-stream -> in_ready=0, buffer holds, no loss or duplication.
- flush asserted with in_valid=1 and a buffered result not consumed -> out_valid=0 next cycle, reg_write_out=0, incoming op absent.
- alu_control=100 accepted -> result 0, reg_write_out=0, illegal_op stays 1 until rst_n pulse. rst_n asserted asynchronously mid-cycle -> outputs clear immediately. Force counter to max-1, then two consumes -> ops_retired holds all-ones.
